data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the MEM-stage data port. It accepts one load/store request at a time over a valid/ready handshake and waits a parameterised number of cycles.
- It then performs the byte/half/word access on an internal word array and returns one registered response pulse carrying load data or an error flag.
- It sits behind the MEM stage and completes the request side of the data-memory interface. The pipeline stalls while req_ready_o is low.

Parameters:
DATA_WIDTH, 32, data and address width in bits (fixed at 32 for byte-lane logic).
DEPTH_WORDS, 1024, number of 32-bit words in the internal array.
LATENCY, 2, wait cycles between acceptance and response (0..15).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_valid_i  input  1  request present.
req_ready_o  output  1  responder can accept a request this cycle.
req_write_i  input  1  1 = store, 0 = load.
req_type_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
req_sign_i  input  1  1 = sign-extend load, 0 = zero-extend.
req_addr_i  input  DATA_WIDTH  byte address.
req_wdata_i  input  DATA_WIDTH  store data, right-aligned.
resp_valid_o  output  1  one-cycle response pulse.
resp_rdata_o  output  DATA_WIDTH  load result.
resp_err_o  output  1  access faulted; qualified by resp_valid_o.
busy_o  output  1  high while in WAIT.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latched request cleared. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready_o = 1 in IDLE and RESP, 0 in WAIT.
- Accept: req_valid_i & req_ready_o at a rising edge k. At that edge the responder latches write, type, sign, addr and wdata.
- Transition on accept: if LATENCY=0, go to RESP; else go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each edge. At counter==0, go to RESP.
- Response timing: resp_valid_o is high for exactly the one cycle between edges k+LATENCY and k+LATENCY+1. There is no response backpressure.
- RESP exit: with a new accept, go to WAIT or RESP (back-to-back). Otherwise go to IDLE.
- Commit point: the store write and the load read both happen at the edge entering RESP. The read samples the array before that same edge's write.
- Throughput: with LATENCY=0, one request per cycle. A store followed immediately by a load to the same address returns the new data, because the store commits one edge earlier.
- Error checks, evaluated on latched fields; any one sets resp_err_o=1:
  - type 11;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- On error: no array write, resp_rdata_o=0.
- Lane selection: little-endian. Lane = addr[1:0].
- Byte load: byte at the lane, extended per sign.
- Half load: bytes lane..lane+1, extended per sign.
- Word load: full word, sign ignored.
- Store byte: wdata[7:0] goes to the lane; other bytes unchanged.
- Store half: wdata[15:0] goes to lanes lane..lane+1.
- Store word: full word written.
- Store response: resp_rdata_o=0.
- Hold: resp_rdata_o and resp_err_o hold their values after resp_valid_o falls, until the next response. busy_o = (state==WAIT).
- Reset mid-operation: the pending request is discarded with no write committed (commit occurs only on RESP entry). Outputs go to reset values immediately.
- Request changes while WAIT: req_* changes are ignored; only latched fields are used.

Test Plan:
1. LATENCY=2. Word store 0xDEADBEEF @0x10, then word load @0x10 -> req_ready_o low for 2 cycles after each accept; resp_valid_o pulses at k+2; load returns 0xDEADBEEF, err 0.
2. After (1), loads:
   - signed byte @0x13 -> 0xFFFFFFDE; unsigned byte @0x13 -> 0x000000DE;
   - signed half @0x12 -> 0xFFFFDEAD; unsigned half @0x10 -> 0x0000BEEF.
3. Byte store 0x5A @0x11 -> word load @0x10 returns 0xDEAD5AEF. Then half store 0x1234 @0x12 -> word load @0x10 returns 0x12345AEF.
4. Each of half @0x11, word @0x12, word @4*DEPTH_WORDS, type 11 -> resp_err_o=1, resp_rdata_o=0. A following word load @0x10 is unchanged (0x12345AEF).
5. LATENCY=0. Word store 0xCAFEF00D @0x20, word load @0x20, byte load unsigned @0x21 on consecutive edges -> req_ready_o stays 1; three consecutive resp_valid_o pulses; loads return 0xCAFEF00D and 0x000000F0.
6. LATENCY=2. Word store 0x11111111 @0x30 after prior 0x22222222 @0x30; assert rst_n low during WAIT -> resp_valid_o/busy_o drop asynchronously; after release, word load @0x30 returns 0x22222222.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-port responder. Accepts one load/store
// over a valid/ready handshake, waits LATENCY cycles, then performs the
// byte/half/word access on an internal word array and returns a single
// registered response pulse carrying load data or an error flag.
module data_mem_responder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [1:0]            req_type_i,
   input  logic                  req_sign_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  busy_o
);

   localparam int unsigned           IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]            CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [DATA_WIDTH-1:0] DEPTH_LIM = DATA_WIDTH'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;

   logic                  lat_write_q;
   logic [1:0]            lat_type_q;
   logic                  lat_sign_q;
   logic [DATA_WIDTH-1:0] lat_addr_q;
   logic [DATA_WIDTH-1:0] lat_wdata_q;

   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_err_q;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

   logic                  accept;
   logic                  enter_resp;
   logic                  c_write;
   logic [1:0]            c_type;
   logic                  c_sign;
   logic [DATA_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_wdata;
   logic [1:0]            c_lane;
   logic [IDX_W-1:0]      c_idx;
   logic                  c_misalign;
   logic                  c_range;
   logic                  c_err;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] c_rdata;
   logic [3:0]            wr_be;
   logic [DATA_WIDTH-1:0] wr_align;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  wr_en;

   assign req_ready_o  = (state_q != ST_WAIT);
   assign busy_o       = (state_q == ST_WAIT);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;

   // Handshake and commit-point detection, plus selection of the request
   // being committed: from WAIT it is the latched one; outside WAIT the
   // only way to enter RESP is a zero-latency accept, so the live inputs
   // are the request (the latch only updates at that same edge).
   always_comb begin
      accept     = req_valid_i & req_ready_o;
      enter_resp = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                   (accept && (LATENCY == 0));
      if (state_q == ST_WAIT) begin
         c_write = lat_write_q;
         c_type  = lat_type_q;
         c_sign  = lat_sign_q;
         c_addr  = lat_addr_q;
         c_wdata = lat_wdata_q;
      end else begin
         c_write = req_write_i;
         c_type  = req_type_i;
         c_sign  = req_sign_i;
         c_addr  = req_addr_i;
         c_wdata = req_wdata_i;
      end
      c_lane = c_addr[1:0];
      c_idx  = c_addr[IDX_W+1:2];
   end

   // Fault classification of the committing request.
   always_comb begin
      c_misalign = ((c_type == 2'b01) && c_addr[0]) ||
                   ((c_type == 2'b10) && (c_addr[1:0] != 2'b00));
      c_range    = ({2'b00, c_addr[DATA_WIDTH-1:2]} >= DEPTH_LIM);
      c_err      = (c_type == 2'b11) | c_misalign | c_range;
   end

   // Load path: read the addressed word, shift the lane down, extend.
   always_comb begin
      rd_word  = mem_q[c_idx];
      rd_shift = rd_word >> {c_lane, 3'b000};
      case (c_type)
         2'b00:   c_rdata = c_sign ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'b0, rd_shift[7:0]};
         2'b01:   c_rdata = c_sign ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'b0, rd_shift[15:0]};
         default: c_rdata = rd_word;
      endcase
      if (c_write || c_err) begin
         c_rdata = '0;
      end
   end

   // Store path: merge the lane-aligned store data into the current word.
   always_comb begin
      case (c_type)
         2'b00:   wr_be = 4'b0001 << c_lane;
         2'b01:   wr_be = 4'b0011 << c_lane;
         default: wr_be = 4'b1111;
      endcase
      wr_align = c_wdata << {c_lane, 3'b000};
      wr_word  = rd_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (wr_be[b]) begin
            wr_word[8*b +: 8] = wr_align[8*b +: 8];
         end
      end
      wr_en = enter_resp & rst_n & c_write & ~c_err;
   end

   // Request FSM with latched request fields and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         lat_write_q  <= 1'b0;
         lat_type_q   <= 2'b00;
         lat_sign_q   <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= enter_resp;
         if (enter_resp) begin
            resp_rdata_q <= c_rdata;
            resp_err_q   <= c_err;
         end
         case (state_q)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  lat_write_q <= req_write_i;
                  lat_type_q  <= req_type_i;
                  lat_sign_q  <= req_sign_i;
                  lat_addr_q  <= req_addr_i;
                  lat_wdata_q <= req_wdata_i;
                  if (LATENCY == 0) begin
                     state_q <= ST_RESP;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Word array write at the commit edge; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[c_idx] <= wr_word;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responder instances (LATENCY=0 with a small
// array, LATENCY=2 with the default array) checked against a byte-level
// reference model, a table of directed vectors and hand-written sequences.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld [2];
   logic        r_wr [2];
   logic [1:0]  r_ty [2];
   logic        r_sg [2];
   logic [31:0] r_ad [2];
   logic [31:0] r_wd [2];
   logic        rdy [2];
   logic        rv [2];
   logic [31:0] rd [2];
   logic        er [2];
   logic        bz [2];

   always #5 clk = ~clk;

   data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(vld[0]), .req_ready_o(rdy[0]), .req_write_i(r_wr[0]),
      .req_type_i(r_ty[0]), .req_sign_i(r_sg[0]), .req_addr_i(r_ad[0]),
      .req_wdata_i(r_wd[0]), .resp_valid_o(rv[0]), .resp_rdata_o(rd[0]),
      .resp_err_o(er[0]), .busy_o(bz[0])
   );

   data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(vld[1]), .req_ready_o(rdy[1]), .req_write_i(r_wr[1]),
      .req_type_i(r_ty[1]), .req_sign_i(r_sg[1]), .req_addr_i(r_ad[1]),
      .req_wdata_i(r_wd[1]), .resp_valid_o(rv[1]), .resp_rdata_o(rd[1]),
      .resp_err_o(er[1]), .busy_o(bz[1])
   );

   typedef struct {
      int unsigned due;
      bit          wr;
      logic [1:0]  t;
      bit          s;
      logic [31:0] a;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      bit          wr;
      logic [1:0]  t;
      bit          s;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      bit          eerr;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   req_t        q [2][$];
   bit          acc [2];
   bit          got [2];
   logic [31:0] cap_rd [2];
   bit          cap_err [2];
   logic [31:0] last_rd [2];
   bit          last_err [2];
   logic [7:0]  mb0 [64];
   logic [7:0]  mb1 [4096];
   vec_t        tbl [18];

   function automatic int unsigned lat(int w);
      return (w == 0) ? 0 : 2;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mset(int w, int unsigned a, logic [7:0] d);
      if (w == 0) mb0[a] = d;
      else        mb1[a] = d;
   endtask

   function automatic logic [7:0] mget(int w, int unsigned a);
      return (w == 0) ? mb0[a] : mb1[a];
   endfunction

   // Reference: byte-addressed little-endian memory, access of n bytes.
   task automatic mdl(int w, req_t r, output bit err, output logic [31:0] res);
      int unsigned n;
      int unsigned depth;
      logic [31:0] v;
      logic [31:0] tmp;
      n     = (r.t == 2'd0) ? 1 : (r.t == 2'd1) ? 2 : 4;
      depth = (w == 0) ? 16 : 1024;
      err   = (r.t == 2'd3) || ((r.a % n) != 0) || ((r.a / 4) >= depth);
      res   = '0;
      if (!err) begin
         if (r.wr) begin
            for (int unsigned i = 0; i < n; i++) begin
               tmp = r.wd >> (8 * i);
               mset(w, r.a + i, tmp[7:0]);
            end
         end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) begin
               v = v | (32'(mget(w, r.a + i)) << (8 * i));
            end
            if (r.s && (n < 4) && v[8*n-1]) begin
               v = v | (32'hFFFF_FFFF << (8 * n));
            end
            res = v;
         end
      end
   endtask

   task automatic mon(int w);
      bit          exp_busy;
      bit          exp_v;
      bit          e;
      logic [31:0] r;
      exp_busy = (q[w].size() > 0) && (q[w][0].due > cyc);
      exp_v    = (q[w].size() > 0) && (q[w][0].due == cyc);
      chk($sformatf("d%0d ready", w), rdy[w], !exp_busy);
      chk($sformatf("d%0d busy", w), bz[w], exp_busy);
      chk($sformatf("d%0d resp_valid", w), rv[w], exp_v);
      if (exp_v) begin
         mdl(w, q[w][0], e, r);
         last_rd[w]  = r;
         last_err[w] = e;
         void'(q[w].pop_front());
      end
      chk($sformatf("d%0d resp_rdata", w), rd[w], last_rd[w]);
      chk($sformatf("d%0d resp_err", w), er[w], last_err[w]);
      if (rv[w] === 1'b1) begin
         got[w]     = 1'b1;
         cap_rd[w]  = rd[w];
         cap_err[w] = er[w];
      end
   endtask

   task automatic tick();
      for (int w = 0; w < 2; w++) begin
         acc[w] = 1'b0;
         if (vld[w] && rdy[w] && rst_n) begin
            q[w].push_back('{due: cyc + 1 + lat(w), wr: r_wr[w], t: r_ty[w],
                             s: r_sg[w], a: r_ad[w], wd: r_wd[w]});
            acc[w] = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int w = 0; w < 2; w++) mon(w);
   endtask

   task automatic setreq(int w, bit iwr, logic [1:0] it, bit is, logic [31:0] ia, logic [31:0] iwd);
      r_wr[w] = iwr;
      r_ty[w] = it;
      r_sg[w] = is;
      r_ad[w] = ia;
      r_wd[w] = iwd;
   endtask

   task automatic xact(int w, bit iwr, logic [1:0] it, bit is, logic [31:0] ia, logic [31:0] iwd);
      int n;
      setreq(w, iwr, it, is, ia, iwd);
      vld[w] = 1'b1;
      got[w] = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc[w] && n < 20);
      vld[w] = 1'b0;
      chk($sformatf("d%0d accept", w), acc[w], 1'b1);
      n = 0;
      while (!got[w] && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("d%0d response seen", w), got[w], 1'b1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r;
      for (int w = 0; w < 2; w++) begin
         vld[w] = 1'b0;
         setreq(w, 1'b0, 2'b10, 1'b0, '0, '0);
         last_rd[w]  = '0;
         last_err[w] = 1'b0;
         got[w]      = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         chk($sformatf("reset d%0d resp_valid", w), rv[w], 1'b0);
         chk($sformatf("reset d%0d rdata", w), rd[w], 32'h0);
         chk($sformatf("reset d%0d err", w), er[w], 1'b0);
         chk($sformatf("reset d%0d ready", w), rdy[w], 1'b1);
         chk($sformatf("reset d%0d busy", w), bz[w], 1'b0);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      for (int unsigned i = 0; i < 16; i++) begin
         xact(0, 1'b1, 2'b10, 1'b0, 4 * i, $urandom);
         xact(1, 1'b1, 2'b10, 1'b0, 4 * i, $urandom);
      end

      tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
      tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'h000000DE, 1'b0};
      tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
      tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
      tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h11,   32'hFFFFFF5A, 32'h0,        1'b0};
      tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEAD5AEF, 1'b0};
      tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h12,   32'hABCD1234, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h12345AEF, 1'b0};
      tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1};
      tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1};
      tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
      tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
      tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h11,   32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[15] = '{1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[16] = '{1'b1, 2'b11, 1'b0, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[17] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h12345AEF, 1'b0};
      for (int i = 0; i < 18; i++) begin
         xact(1, tbl[i].wr, tbl[i].t, tbl[i].s, tbl[i].a, tbl[i].wd);
         chk($sformatf("tbl%0d rdata", i), cap_rd[1], tbl[i].erd);
         chk($sformatf("tbl%0d err", i), cap_err[1], tbl[i].eerr);
      end

      // Zero latency, three back-to-back requests on consecutive edges.
      vld[0] = 1'b1;
      setreq(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
      chk("b2b ready0", rdy[0], 1'b1);
      tick();
      chk("b2b acc0", acc[0], 1'b1);
      chk("b2b valid0", rv[0], 1'b1);
      chk("b2b rdata0", rd[0], 32'h0);
      setreq(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      chk("b2b ready1", rdy[0], 1'b1);
      tick();
      chk("b2b acc1", acc[0], 1'b1);
      chk("b2b valid1", rv[0], 1'b1);
      chk("b2b rdata1", rd[0], 32'hCAFEF00D);
      setreq(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
      chk("b2b ready2", rdy[0], 1'b1);
      tick();
      chk("b2b acc2", acc[0], 1'b1);
      chk("b2b valid2", rv[0], 1'b1);
      chk("b2b rdata2", rd[0], 32'h000000F0);
      vld[0] = 1'b0;
      tick();
      chk("b2b valid end", rv[0], 1'b0);
      chk("b2b hold", rd[0], 32'h000000F0);

      // Reset while a store waits: nothing may be committed.
      xact(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h22222222);
      xact(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      chk("rst pre load", cap_rd[1], 32'h22222222);
      vld[1] = 1'b1;
      setreq(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111);
      tick();
      chk("rst acc", acc[1], 1'b1);
      vld[1] = 1'b0;
      tick();
      chk("rst busy before", bz[1], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst busy async", bz[1], 1'b0);
      chk("rst valid async", rv[1], 1'b0);
      chk("rst rdata async", rd[1], 32'h0);
      chk("rst ready async", rdy[1], 1'b1);
      for (int w = 0; w < 2; w++) begin
         q[w].delete();
         last_rd[w]  = '0;
         last_err[w] = 1'b0;
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      xact(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      chk("rst no commit", cap_rd[1], 32'h22222222);

      // Randomized traffic on both instances, inputs churning every cycle.
      for (int n = 0; n < 500; n++) begin
         for (int w = 0; w < 2; w++) begin
            vld[w] = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 19);
            if (r < 18)       r_ad[w] = $urandom_range(0, 63);
            else if (r == 18) r_ad[w] = (w == 0) ? $urandom_range(64, 79) : 32'h1000 + $urandom_range(0, 15);
            else              r_ad[w] = $urandom | 32'h8000_0000;
            r_wr[w] = 1'($urandom_range(0, 1));
            r_ty[w] = 2'($urandom_range(0, 3));
            r_sg[w] = 1'($urandom_range(0, 1));
            r_wd[w] = $urandom;
         end
         tick();
      end
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
